// File: rtl/memory_access_if.sv
// Data-memory request/acknowledge port between the MEM stage and the data memory.
interface memory_access_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic [31:0] dmem_rdata_i;
  logic        dmem_ack_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_rdata_i, dmem_ack_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_rdata_i, dmem_ack_i
  );
endinterface

// File: rtl/memory_access.sv
// MEM stage: byte/half/word loads and stores over a req/ack memory port, registered into WB.
// Latency 1 cycle for ALU ops, 2+ for memory ops; stall_o holds Execute while an access is in flight.
module memory_access (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic                  mem_rd_i,
  input  logic                  mem_wr_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           store_data_i,
  input  logic [4:0]            load_dest_i,
  input  logic [31:0]           result_i,
  input  logic [31:0]           result2_i,
  input  logic [4:0]            destination_i,
  input  logic [4:0]            destination2_i,
  input  logic [31:0]           PSW_i,
  memory_access_if.master       dmem,
  output logic [31:0]           result_o,
  output logic [31:0]           result2_o,
  output logic [4:0]            destination_o,
  output logic [4:0]            destination2_o,
  output logic [31:0]           wb_data_o,
  output logic [4:0]            mem_destination_o,
  output logic [31:0]           PSW_o,
  output logic                  stall_o,
  output logic                  misalign_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]  state;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;

  logic        lat_rd;
  logic        lat_unsigned;
  logic [1:0]  lat_size;
  logic [1:0]  lat_lo;
  logic [4:0]  lat_load_dest;
  logic [31:0] lat_result;
  logic [31:0] lat_result2;
  logic [4:0]  lat_dest;
  logic [4:0]  lat_dest2;
  logic [31:0] lat_psw;

  logic        mem_op;
  logic        misal;
  logic        bad_req;
  logic        accept;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] rd_shift;
  logic [31:0] load_ext;

  assign mem_op  = mem_rd_i | mem_wr_i;
  assign bad_req = (state == IDLE) & valid_i & mem_op & (misal | (mem_rd_i & mem_wr_i));
  assign accept  = (state == IDLE) & valid_i & (mem_rd_i ^ mem_wr_i) & ~misal;

  assign stall_o           = (state == WAIT);
  assign dmem.dmem_req_o   = (state == WAIT);
  assign dmem.dmem_we_o    = bus_we;
  assign dmem.dmem_addr_o  = bus_addr;
  assign dmem.dmem_be_o    = bus_be;
  assign dmem.dmem_wdata_o = bus_wdata;

  always_comb begin
    misal      = 1'b0;
    be_next    = 4'b1111;
    wdata_next = store_data_i;
    case (size_i)
      2'b00: begin
        be_next    = 4'b0001 << addr_i[1:0];
        wdata_next = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        misal      = addr_i[0];
        be_next    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{store_data_i[15:0]}};
      end
      2'b10:   misal = |addr_i[1:0];
      default: misal = 1'b1;
    endcase
  end

  // Byte lane is brought down to bit 0 first; halfword lane picked by addr[1].
  assign rd_shift = dmem.dmem_rdata_i >> {lat_lo, 3'b000};

  always_comb begin
    load_ext = dmem.dmem_rdata_i;
    case (lat_size)
      2'b00:   load_ext = {{24{~lat_unsigned & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_ext = lat_lo[1] ?
                 {{16{~lat_unsigned & dmem.dmem_rdata_i[31]}}, dmem.dmem_rdata_i[31:16]} :
                 {{16{~lat_unsigned & dmem.dmem_rdata_i[15]}}, dmem.dmem_rdata_i[15:0]};
      default: load_ext = dmem.dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      bus_we            <= 1'b0;
      bus_addr          <= 32'd0;
      bus_be            <= 4'd0;
      bus_wdata         <= 32'd0;
      lat_rd            <= 1'b0;
      lat_unsigned      <= 1'b0;
      lat_size          <= 2'd0;
      lat_lo            <= 2'd0;
      lat_load_dest     <= 5'd0;
      lat_result        <= 32'd0;
      lat_result2       <= 32'd0;
      lat_dest          <= 5'd0;
      lat_dest2         <= 5'd0;
      lat_psw           <= 32'd0;
      result_o          <= 32'd0;
      result2_o         <= 32'd0;
      destination_o     <= 5'd0;
      destination2_o    <= 5'd0;
      wb_data_o         <= 32'd0;
      mem_destination_o <= 5'd0;
      PSW_o             <= 32'd0;
      misalign_o        <= 1'b0;
    end else begin
      // Bubble by default; overridden below when something retires.
      result_o          <= 32'd0;
      result2_o         <= 32'd0;
      destination_o     <= 5'd0;
      destination2_o    <= 5'd0;
      wb_data_o         <= 32'd0;
      mem_destination_o <= 5'd0;
      PSW_o             <= PSW_i;
      misalign_o        <= bad_req;
      case (state)
        IDLE: begin
          if (valid_i && !mem_op) begin
            result_o       <= result_i;
            result2_o      <= result2_i;
            destination_o  <= destination_i;
            destination2_o <= destination2_i;
          end
          if (accept) begin
            state         <= WAIT;
            bus_we        <= mem_wr_i;
            bus_addr      <= {addr_i[31:2], 2'b00};
            bus_be        <= be_next;
            bus_wdata     <= wdata_next;
            lat_rd        <= mem_rd_i;
            lat_unsigned  <= unsigned_i;
            lat_size      <= size_i;
            lat_lo        <= addr_i[1:0];
            lat_load_dest <= load_dest_i;
            lat_result    <= result_i;
            lat_result2   <= result2_i;
            lat_dest      <= destination_i;
            lat_dest2     <= destination2_i;
            lat_psw       <= PSW_i;
          end
        end
        default: begin
          if (dmem.dmem_ack_i) begin
            state             <= IDLE;
            result_o          <= lat_result;
            result2_o         <= lat_result2;
            destination_o     <= lat_dest;
            destination2_o    <= lat_dest2;
            PSW_o             <= lat_psw;
            wb_data_o         <= lat_rd ? load_ext : 32'd0;
            mem_destination_o <= lat_rd ? lat_load_dest : 5'd0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: vector table for single-cycle ops plus memory sequences.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0, mem_rd_i = 1'b0, mem_wr_i = 1'b0, unsigned_i = 1'b0;
  logic [1:0]  size_i = 2'd0;
  logic [31:0] addr_i = '0, store_data_i = '0, result_i = '0, result2_i = '0, PSW_i = '0;
  logic [4:0]  load_dest_i = '0, destination_i = '0, destination2_i = '0;
  logic [31:0] result_o, result2_o, wb_data_o, PSW_o;
  logic [4:0]  destination_o, destination2_o, mem_destination_o;
  logic        stall_o, misalign_o;

  int tests = 0;
  int fails = 0;

  memory_access_if mif ();

  memory_access dut (
    .clk(clk), .rst_n(rst_n),
    .valid_i(valid_i), .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .addr_i(addr_i), .store_data_i(store_data_i),
    .load_dest_i(load_dest_i), .result_i(result_i), .result2_i(result2_i),
    .destination_i(destination_i), .destination2_i(destination2_i), .PSW_i(PSW_i),
    .dmem(mif),
    .result_o(result_o), .result2_o(result2_o), .destination_o(destination_o),
    .destination2_o(destination2_o), .wb_data_o(wb_data_o),
    .mem_destination_o(mem_destination_o), .PSW_o(PSW_o), .stall_o(stall_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld, rd, wr;
    logic [1:0]  size;
    logic [31:0] addr, res, res2, psw;
    logic [4:0]  dst, dst2;
    logic [31:0] e_res, e_res2;
    logic [4:0]  e_dst, e_dst2;
    logic        e_mis;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_mem(input string nm, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] sd,
                        input int lat, input logic [31:0] rdata, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input logic [31:0] e_wb,
                        input logic [4:0] e_md);
    int n;
    valid_i = 1'b1; mem_rd_i = rd; mem_wr_i = wr; size_i = sz; unsigned_i = uns;
    addr_i = addr; store_data_i = sd; load_dest_i = 5'd9;
    result_i = 32'h0000_1234 + addr; result2_i = 32'h0; destination_i = 5'd6;
    destination2_i = 5'd0; PSW_i = 32'h40;
    mif.dmem_ack_i = 1'b0;
    tick();
    chk({nm, " req"}, {31'd0, mif.dmem_req_o}, 32'd1);
    chk({nm, " we"}, {31'd0, mif.dmem_we_o}, {31'd0, wr});
    chk({nm, " addr"}, mif.dmem_addr_o, {addr[31:2], 2'b00});
    chk({nm, " be"}, {28'd0, mif.dmem_be_o}, {28'd0, e_be});
    if (wr) chk({nm, " wdata"}, mif.dmem_wdata_o, e_wdata);
    chk({nm, " bubble dst"}, {27'd0, destination_o}, 32'd0);
    n = 0;
    for (int i = 0; i < lat; i++) begin
      if (stall_o) n++;
      tick();
    end
    mif.dmem_ack_i = 1'b1;
    mif.dmem_rdata_i = rdata;
    #1;
    if (stall_o) n++;
    @(posedge clk);
    #1;
    mif.dmem_ack_i = 1'b0;
    chk({nm, " stall cycles"}, n, lat + 1);
    chk({nm, " stall low"}, {31'd0, stall_o}, 32'd0);
    chk({nm, " wb_data"}, wb_data_o, e_wb);
    chk({nm, " mem_dest"}, {27'd0, mem_destination_o}, {27'd0, e_md});
    chk({nm, " result"}, result_o, 32'h0000_1234 + addr);
    chk({nm, " dest"}, {27'd0, destination_o}, 32'd6);
    valid_i = 1'b0; mem_rd_i = 1'b0; mem_wr_i = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    mif.dmem_ack_i = 1'b0;
    mif.dmem_rdata_i = 32'd0;
    //           vld rd wr size  addr          res           res2          psw     dst   dst2  e_res         e_res2        e_dst e_dst2 mis
    vecs[0] = '{1, 0, 0, 2'b10, 32'h0,        32'h12345678, 32'h0BADF00D, 32'h20, 5'd5, 5'd3, 32'h12345678, 32'h0BADF00D, 5'd5, 5'd3, 0};
    vecs[1] = '{0, 0, 0, 2'b00, 32'h0,        32'h0000FFFF, 32'h1,        32'h01, 5'd4, 5'd2, 32'h0,        32'h0,        5'd0, 5'd0, 0};
    vecs[2] = '{1, 1, 0, 2'b10, 32'h3001,     32'h11111111, 32'h2,        32'h02, 5'd8, 5'd0, 32'h0,        32'h0,        5'd0, 5'd0, 1};
    vecs[3] = '{1, 0, 0, 2'b00, 32'h0,        32'hDEADBEEF, 32'h3,        32'h03, 5'd31, 5'd1, 32'hDEADBEEF, 32'h3,       5'd31, 5'd1, 0};
    vecs[4] = '{1, 0, 1, 2'b01, 32'h2001,     32'h5,        32'h4,        32'h04, 5'd7, 5'd0, 32'h0,        32'h0,        5'd0, 5'd0, 1};
    vecs[5] = '{1, 1, 0, 2'b11, 32'h0,        32'h6,        32'h5,        32'h05, 5'd7, 5'd0, 32'h0,        32'h0,        5'd0, 5'd0, 1};
    vecs[6] = '{1, 1, 1, 2'b00, 32'h0,        32'h7,        32'h6,        32'h06, 5'd7, 5'd0, 32'h0,        32'h0,        5'd0, 5'd0, 1};
    vecs[7] = '{0, 0, 0, 2'b00, 32'h0,        32'h8,        32'h7,        32'h07, 5'd1, 5'd1, 32'h0,        32'h0,        5'd0, 5'd0, 0};

    #12;
    chk("reset result", result_o, 32'd0);
    chk("reset psw", PSW_o, 32'd0);
    chk("reset req", {31'd0, mif.dmem_req_o}, 32'd0);
    chk("reset stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      valid_i = vecs[i].vld; mem_rd_i = vecs[i].rd; mem_wr_i = vecs[i].wr;
      size_i = vecs[i].size; addr_i = vecs[i].addr; result_i = vecs[i].res;
      result2_i = vecs[i].res2; PSW_i = vecs[i].psw; destination_i = vecs[i].dst;
      destination2_i = vecs[i].dst2;
      tick();
      chk($sformatf("v%0d result", i), result_o, vecs[i].e_res);
      chk($sformatf("v%0d result2", i), result2_o, vecs[i].e_res2);
      chk($sformatf("v%0d dest", i), {27'd0, destination_o}, {27'd0, vecs[i].e_dst});
      chk($sformatf("v%0d dest2", i), {27'd0, destination2_o}, {27'd0, vecs[i].e_dst2});
      chk($sformatf("v%0d mem_dest", i), {27'd0, mem_destination_o}, 32'd0);
      chk($sformatf("v%0d misalign", i), {31'd0, misalign_o}, {31'd0, vecs[i].e_mis});
      chk($sformatf("v%0d req", i), {31'd0, mif.dmem_req_o}, 32'd0);
      chk($sformatf("v%0d stall", i), {31'd0, stall_o}, 32'd0);
      chk($sformatf("v%0d psw", i), PSW_o, vecs[i].psw);
    end
    valid_i = 1'b0;

    do_mem("ld.b", 1, 0, 2'b00, 0, 32'h1002, 32'h0, 3, 32'h00800000, 4'b0100, 32'h0, 32'hFFFFFF80, 5'd9);
    do_mem("ld.bu", 1, 0, 2'b00, 1, 32'h1002, 32'h0, 3, 32'h00800000, 4'b0100, 32'h0, 32'h00000080, 5'd9);
    do_mem("st.h", 0, 1, 2'b01, 0, 32'h2002, 32'hCAFEBEEF, 0, 32'h0, 4'b1100, 32'hBEEFBEEF, 32'h0, 5'd0);
    do_mem("st.b", 0, 1, 2'b00, 0, 32'h2003, 32'h000000A7, 1, 32'h0, 4'b1000, 32'hA7A7A7A7, 32'h0, 5'd0);

    // Reset during an outstanding load must clear everything without a clock edge.
    valid_i = 1'b1; mem_rd_i = 1'b1; size_i = 2'b10; addr_i = 32'h6000; PSW_i = 32'h55;
    tick();
    tick();
    chk("pre-rst psw", PSW_o, 32'h55);
    chk("pre-rst stall", {31'd0, stall_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst req", {31'd0, mif.dmem_req_o}, 32'd0);
    chk("async rst stall", {31'd0, stall_o}, 32'd0);
    chk("async rst psw", PSW_o, 32'd0);
    valid_i = 1'b0; mem_rd_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_mem("ld.hu", 1, 0, 2'b01, 1, 32'h4000, 32'h0, 2, 32'h0000F00D, 4'b0011, 32'h0, 32'h0000F00D, 5'd9);
    do_mem("ld.h hi", 1, 0, 2'b01, 0, 32'h4002, 32'h0, 1, 32'h8001F00D, 4'b1100, 32'h0, 32'hFFFF8001, 5'd9);

    // Word load then an ALU op that Execute held until stall dropped.
    do_mem("ld.w", 1, 0, 2'b10, 1, 32'h5000, 32'h0, 1, 32'h80000001, 4'b1111, 32'h0, 32'h80000001, 5'd9);
    valid_i = 1'b1; result_i = 32'hAAAA5555; destination_i = 5'd7;
    tick();
    chk("b2b alu result", result_o, 32'hAAAA5555);
    chk("b2b alu dest", {27'd0, destination_o}, 32'd7);
    chk("b2b alu mem_dest", {27'd0, mem_destination_o}, 32'd0);
    chk("b2b alu wb_data", wb_data_o, 32'd0);
    chk("b2b alu stall", {31'd0, stall_o}, 32'd0);
    valid_i = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
